// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// One transaction in flight at a time; data wins ties; flushed fetch responses are dropped.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_valid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_f,
  output logic                stall_m
);

  typedef enum logic [1:0] {StIdle, StWaitI, StWaitD} state_e;

  state_e state_q, state_d;
  logic   drop_q, drop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    i_valid   = 1'b0;
    i_rdata   = '0;
    d_valid   = 1'b0;
    d_rdata   = '0;
    // Every output is held at zero while reset is asserted, regardless of inputs.
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          if (d_req) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
            if (mem_gnt) state_d = StWaitD;
          end else if (i_req && !i_flush) begin
            mem_req  = 1'b1;
            mem_addr = i_addr;
            if (mem_gnt) state_d = StWaitI;
          end
        end
        StWaitI: begin
          if (i_flush) drop_d = 1'b1;
          if (mem_rvalid) begin
            state_d = StIdle;
            drop_d  = 1'b0;
            if (!drop_q && !i_flush) begin
              i_valid = 1'b1;
              i_rdata = mem_rdata;
            end
          end
        end
        StWaitD: begin
          if (mem_rvalid) begin
            state_d = StIdle;
            d_valid = 1'b1;
            d_rdata = mem_rdata;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    stall_f = rst_n & i_req & ~i_valid & ~i_flush;
    stall_m = rst_n & d_req & ~d_valid;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single unified memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage, loads and stores). It issues one transaction at a time, returns each response to the requester that issued it, and drops fetch responses cancelled by a taken branch or jump. It drives stall requests into the pipeline hazard logic, which freezes the waiting stage.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-strobe width is DATA_W/8

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held stable until i_valid, or until dropped by i_flush
- i_addr  in  ADDR_W  fetch address
- i_flush  in  1  control-hazard flush (taken branch/jump in EX); cancels the current fetch
- i_valid  out  1  fetch data valid, 1-cycle pulse
- i_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte enables
- d_valid  out  1  data access complete, 1-cycle pulse (load data or store ack)
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory request
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  request fields; zero when mem_req=0 and forced to 0 for fetches (mem_we, mem_wdata, mem_wstrb)
- mem_gnt  in  1  memory accepts the request in the current cycle
- mem_rvalid  in  1  response pulse, one per granted request, at least 1 cycle after mem_gnt
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid
- stall_f  out  1  freeze the IF stage
- stall_m  out  1  freeze the MEM stage and everything upstream of it

## Operation
- FSM states: IDLE, WAIT_I, WAIT_D. Registered state: fsm, drop flag.
- IDLE:
  - If d_req: mem_req=1 with the data fields. Data has fixed priority over fetch because it belongs to the older instruction.
  - Else if i_req and not i_flush: mem_req=1 with i_addr, mem_we=0.
  - mem_gnt=1 moves to WAIT_D or WAIT_I, according to the requester presented. mem_gnt=0 keeps IDLE, and the choice is re-evaluated next cycle.
- WAIT_I / WAIT_D:
  - mem_req=0.
  - On mem_rvalid: pass mem_rdata to the owner's rdata and pulse its valid (combinational, same cycle), then go to IDLE.
  - mem_gnt while mem_req=0 is ignored.
- Flush:
  - i_flush in WAIT_I sets drop. The matching mem_rvalid then produces no i_valid, and drop clears.
  - i_flush in the same cycle as mem_rvalid in WAIT_I also suppresses i_valid.
  - i_flush in IDLE masks fetch arbitration for that cycle.
  - i_flush has no effect on data transactions.
- Stalls:
  - stall_f = i_req & ~i_valid & ~i_flush.
  - stall_m = d_req & ~d_valid.
- i_rdata and d_rdata are 0 when their valid is low.
- mem_rvalid in IDLE (protocol violation) is ignored; no valid pulse is produced.

## Timing
- Reset (rst_n low, asynchronous): fsm=IDLE, drop=0. All outputs are 0 while rst_n is low, including mem_req, even if requests are present.
- Reset mid-transaction: the outstanding response is discarded. After release the FSM starts in IDLE and re-arbitrates.
- Latency: request with mem_gnt in cycle t, mem_rvalid in cycle t+L (L≥1), valid in t+L. The next issue is possible in t+L+1.
- Peak throughput is one access per 2 cycles.
- A pending fetch waits behind every data access. A data request arriving while WAIT_I is served after the fetch completes.

## Test plan
- Fetch only: i_req=1, i_addr=0x100, mem_gnt same cycle, mem_rvalid 2 cycles later with 0x00500093 -> i_valid pulses once with i_rdata=0x00500093; stall_f=1 until that cycle; mem_req=0 while in WAIT_I.
- Collision: i_req and d_req (load, d_addr=0x2000) both rise in IDLE -> data is issued first and d_valid returns 0xDEADBEEF. The fetch issues in the cycle after d_valid; stall_f stays high throughout.
- Store: d_we=1, d_addr=0x2004, d_wdata=0x12345678, d_wstrb=4'b0011 -> mem fields match exactly; d_valid pulses on the ack; d_rdata=0.
- Flush in flight: fetch of 0x104 granted, i_flush pulses in WAIT_I, mem_rvalid 3 cycles later -> no i_valid. The next fetch at 0x200 issues in the following IDLE cycle and returns normally.
- Grant backpressure: d_req with mem_gnt low for 4 cycles -> mem_req and fields held constant for 4 cycles; stall_m=1 until d_valid.
- Async reset mid-WAIT_D: rst_n low between edges -> mem_req, d_valid and stall_m are 0 immediately. After release the FSM is in IDLE and a late mem_rvalid produces no valid.
